// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer with CTRL/PRESET/COUNT registers,
// one-shot (held IRQ) and auto-reload (pulsed IRQ) modes. Define TIMER_STATUS_REG_EN for STATUS at Addr 3.
module timer_device #(
    parameter int unsigned PRESCALE   = 1,
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Sel,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic [15:0] presc_q, presc_d;
    logic        flag_q, flag_d;

    logic wr_ctrl;
    logic wr_preset;
    logic reload;

    assign wr_ctrl   = Sel && WE && (Addr == 2'd0);
    assign wr_preset = Sel && WE && (Addr == 2'd1);
    assign reload    = (mode_q == 2'd1);

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        presc_d  = presc_q;
        flag_d   = flag_q;

        // Clears come first so that the INT set below wins on the same edge.
        if (reload) flag_d = 1'b0;
        if (wr_ctrl || wr_preset) flag_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = preset_q;
                    presc_d = 16'd0;
                    state_d = (preset_q == 32'd0) ? S_INT : S_CNT;
                end
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = 16'd0;
                    if (count_q != 32'd0) count_d = count_q - 32'd1;
                    if (count_q <= 32'd1) state_d = S_INT;
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
            S_INT: begin
                flag_d = 1'b1;
                if (reload) begin
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_preset) preset_d = Din;

        // A CTRL write parks the FSM in IDLE and freezes the count; the new Enable
        // is acted on at the following edge, so a rewrite restarts from PRESET.
        if (wr_ctrl) begin
            en_d    = Din[0];
            mode_d  = Din[2:1];
            im_d    = Din[3];
            state_d = S_IDLE;
            count_d = count_q;
            presc_d = presc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'd0;
            im_q     <= 1'b0;
            preset_q <= PRESET_RST;
            count_q  <= 32'd0;
            presc_q  <= 16'd0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            flag_q   <= flag_d;
        end
    end

    assign IRQ = flag_q & im_q;

`ifdef TIMER_STATUS_REG_EN
    logic wr_status;
    logic expired_q, expired_d;

    assign wr_status = Sel && WE && (Addr == 2'd3);

    always_comb begin
        expired_d = expired_q;
        if (wr_status) expired_d = 1'b0;
        if ((state_d == S_INT) && (state_q != S_INT)) expired_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) expired_q <= 1'b0;
        else       expired_q <= expired_d;
    end
`endif

    always_comb begin
        Dout = 32'd0;
        if (Sel) begin
            unique case (Addr)
                2'd0: Dout = {28'd0, im_q, mode_q, en_q};
                2'd1: Dout = preset_q;
                2'd2: Dout = count_q;
`ifdef TIMER_STATUS_REG_EN
                2'd3: Dout = {30'd0, IRQ, expired_q};
`else
                2'd3: Dout = 32'd0;
`endif
                default: Dout = 32'd0;
            endcase
        end
    end

endmodule
